// File: rtl/eco32f_wb_pkg.sv
// Shared Wishbone constants and arbiter state encodings for the eco32f bus fabric.
package eco32f_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } grant_e;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } master_e;

endpackage

// File: rtl/eco32f_wb_arbiter_if.sv
// Wishbone B3 request/response bundle; read data bypasses the arbiter, so dat is write data only.
interface eco32f_wb_arbiter_if;
    logic [31:0] adr;
    logic        stb;
    logic        cyc;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat;
    logic        ack;
    logic        err;

    modport master (output adr, stb, cyc, sel, we, cti, bte, dat, input ack, err);
    modport slave  (input adr, stb, cyc, sel, we, cti, bte, dat, output ack, err);
endinterface

// File: rtl/eco32f_wb_watchdog.sv
// Stall counter: counts cycles of an outstanding strobe and pulses expired at TIMEOUT (0 disables).
module eco32f_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [W-1:0] cnt_q;

    assign expired = (TIMEOUT != 0) && (cnt_q == W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || clr || expired || !run || TIMEOUT == 0)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/eco32f_wb_arbiter.sv
// Fetch/LSU to external bus arbiter; grant is held for a whole cyc so wrap refills never interleave.
module eco32f_wb_arbiter
    import eco32f_wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    eco32f_wb_arbiter_if.slave          iwbm,
    eco32f_wb_arbiter_if.slave          dwbm,
    eco32f_wb_arbiter_if.master         wbs
);
    grant_e  grant_q, grant_d;
    master_e last_q, last_d;
    logic    stb_g;
    logic    tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= IDLE;
            last_q  <= MST_I;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        case (grant_q)
            IDLE: begin
                if (iwbm.cyc && dwbm.cyc)
                    grant_d = (last_q == MST_I) ? GNT_D : GNT_I;
                else if (iwbm.cyc)
                    grant_d = GNT_I;
                else if (dwbm.cyc)
                    grant_d = GNT_D;
            end
            GNT_I: if (!iwbm.cyc) grant_d = dwbm.cyc ? GNT_D : IDLE;
            GNT_D: if (!dwbm.cyc) grant_d = iwbm.cyc ? GNT_I : IDLE;
            default: grant_d = IDLE;
        endcase
        if (grant_d == GNT_I && grant_q != GNT_I) last_d = MST_I;
        if (grant_d == GNT_D && grant_q != GNT_D) last_d = MST_D;
    end

    // Fetch has no byte lanes or writes: present full-word reads to the slave.
    always_comb begin
        wbs.adr = '0;
        wbs.stb = 1'b0;
        wbs.cyc = 1'b0;
        wbs.sel = '0;
        wbs.we  = 1'b0;
        wbs.cti = '0;
        wbs.bte = '0;
        wbs.dat = '0;
        stb_g   = 1'b0;
        case (grant_q)
            GNT_I: begin
                wbs.adr = iwbm.adr;
                wbs.stb = iwbm.stb;
                wbs.cyc = iwbm.cyc;
                wbs.sel = 4'b1111;
                wbs.cti = iwbm.cti;
                wbs.bte = iwbm.bte;
                stb_g   = iwbm.stb;
            end
            GNT_D: begin
                wbs.adr = dwbm.adr;
                wbs.stb = dwbm.stb;
                wbs.cyc = dwbm.cyc;
                wbs.sel = dwbm.sel;
                wbs.we  = dwbm.we;
                wbs.cti = dwbm.cti;
                wbs.bte = dwbm.bte;
                wbs.dat = dwbm.dat;
                stb_g   = dwbm.stb;
            end
            default: ;
        endcase
        // Abandon the hung access on the bus in the cycle the synthetic err is returned.
        if (tmo) begin
            wbs.stb = 1'b0;
            wbs.cyc = 1'b0;
        end
    end

    eco32f_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .run     (stb_g && !wbs.ack && !wbs.err),
        .clr     (grant_d != grant_q),
        .expired (tmo)
    );

    assign iwbm.ack = wbs.ack && grant_q == GNT_I && iwbm.stb;
    assign iwbm.err = (wbs.err || tmo) && grant_q == GNT_I && iwbm.stb;
    assign dwbm.ack = wbs.ack && grant_q == GNT_D && dwbm.stb;
    assign dwbm.err = (wbs.err || tmo) && grant_q == GNT_D && dwbm.stb;
endmodule

// File: tb/tb_eco32f_wb_arbiter.sv
// Directed bench for eco32f_wb_arbiter with a short watchdog (TIMEOUT=4).
module tb_eco32f_wb_arbiter;
    import eco32f_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eco32f_wb_arbiter_if iwbm ();
    eco32f_wb_arbiter_if dwbm ();
    eco32f_wb_arbiter_if wbs ();

    eco32f_wb_arbiter #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .iwbm (iwbm),
        .dwbm (dwbm),
        .wbs  (wbs)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Junk on the fetch port's unused lanes proves the arbiter forces sel/we/dat.
    task automatic idle_all();
        iwbm.adr = '0; iwbm.stb = 0; iwbm.cyc = 0; iwbm.sel = 4'h0; iwbm.we = 1;
        iwbm.cti = '0; iwbm.bte = '0; iwbm.dat = 32'hDEAD_BEEF;
        dwbm.adr = '0; dwbm.stb = 0; dwbm.cyc = 0; dwbm.sel = '0; dwbm.we = 0;
        dwbm.cti = '0; dwbm.bte = '0; dwbm.dat = '0;
        wbs.ack = 0; wbs.err = 0;
    endtask

    task automatic req_i(input logic [31:0] a, input logic [2:0] cti, input logic [1:0] bte);
        iwbm.adr = a; iwbm.cti = cti; iwbm.bte = bte; iwbm.cyc = 1; iwbm.stb = 1;
    endtask

    task automatic req_d(input logic [31:0] a, input logic we, input logic [3:0] sel,
                         input logic [31:0] d);
        dwbm.adr = a; dwbm.we = we; dwbm.sel = sel; dwbm.dat = d;
        dwbm.cti = CTI_CLASSIC; dwbm.bte = '0; dwbm.cyc = 1; dwbm.stb = 1;
    endtask

    task automatic drop_i(); iwbm.cyc = 0; iwbm.stb = 0; endtask
    task automatic drop_d(); dwbm.cyc = 0; dwbm.stb = 0; endtask

    initial begin
        logic [31:0] badr;
        idle_all();
        rst = 1;
        step(); step();
        rst = 0;
        #1;
        chk("rst_cyc", wbs.cyc, 0);
        chk("rst_stb", wbs.stb, 0);
        chk("rst_adr", wbs.adr, 0);
        chk("rst_iack", iwbm.ack, 0);
        chk("rst_dack", dwbm.ack, 0);

        // Simultaneous request after reset: D first, one idle bus cycle, then I.
        step();
        req_i(32'h0000_2000, CTI_CLASSIC, 2'b00);
        req_d(32'h0000_0100, 1, 4'b0011, 32'hCAFE_F00D);
        #1 chk("sim_lat_cyc", wbs.cyc, 0);
        step();
        #1;
        chk("sim_d_cyc", wbs.cyc, 1);
        chk("sim_d_adr", wbs.adr, 32'h0000_0100);
        chk("sim_d_sel", wbs.sel, 4'b0011);
        chk("sim_d_we", wbs.we, 1);
        chk("sim_d_dat", wbs.dat, 32'hCAFE_F00D);
        wbs.ack = 1;
        #1;
        chk("sim_d_ack", dwbm.ack, 1);
        chk("sim_d_iack", iwbm.ack, 0);
        step();
        wbs.ack = 0; drop_d();
        #1 chk("sim_gap", wbs.cyc, 0);
        step();
        #1;
        chk("sim_i_cyc", wbs.cyc, 1);
        chk("sim_i_adr", wbs.adr, 32'h0000_2000);
        chk("sim_i_sel", wbs.sel, 4'b1111);
        chk("sim_i_we", wbs.we, 0);
        chk("sim_i_dat", wbs.dat, 0);
        wbs.ack = 1;
        #1;
        chk("sim_i_ack", iwbm.ack, 1);
        chk("sim_i_dack", dwbm.ack, 0);
        step();
        wbs.ack = 0; drop_i();
        step(); step();

        // 8-beat wrap refill; D request at beat 3 must wait for I to drop cyc.
        req_i(32'h0000_3008, CTI_INCR, BTE_WRAP8);
        step();
        for (int b = 0; b < 8; b++) begin
            badr = 32'h0000_3000 | ((32'h8 + 32'(b) * 4) & 32'h1C);
            iwbm.adr = badr;
            iwbm.cti = (b == 7) ? CTI_EOB : CTI_INCR;
            wbs.ack = 1;
            if (b == 3) req_d(32'h0000_9000, 1, 4'hF, 32'h0000_1234);
            #1;
            chk("bst_iack", iwbm.ack, 1);
            chk("bst_dack", dwbm.ack, 0);
            chk("bst_adr", wbs.adr, badr);
            chk("bst_cti", wbs.cti, (b == 7) ? 32'(CTI_EOB) : 32'(CTI_INCR));
            step();
        end
        drop_i(); wbs.ack = 0;
        #1 chk("bst_gap", wbs.cyc, 0);
        step();
        #1;
        chk("bst_d_adr", wbs.adr, 32'h0000_9000);
        chk("bst_d_dat", wbs.dat, 32'h0000_1234);
        chk("bst_d_bte", wbs.bte, 0);
        wbs.ack = 1;
        #1 chk("bst_d_ack", dwbm.ack, 1);
        step();
        wbs.ack = 0; drop_d();
        step(); step();

        // Back-to-back requests: last grant was D, so I wins first, then alternate.
        req_i(32'h0000_4000, CTI_CLASSIC, 2'b00);
        req_d(32'h0000_5000, 0, 4'hF, 32'h0);
        step();
        for (int r = 0; r < 4; r++) begin
            #1 chk("alt_adr", wbs.adr, r[0] ? 32'h0000_5000 : 32'h0000_4000);
            wbs.ack = 1;
            #1;
            chk("alt_ack", r[0] ? dwbm.ack : iwbm.ack, 1);
            chk("alt_noack", r[0] ? iwbm.ack : dwbm.ack, 0);
            step();
            wbs.ack = 0;
            if (r[0]) drop_d(); else drop_i();
            #1 chk("alt_gap", wbs.cyc, 0);
            step();
            if (r[0]) req_d(32'h0000_5000, 0, 4'hF, 32'h0);
            else      req_i(32'h0000_4000, CTI_CLASSIC, 2'b00);
        end
        drop_i(); drop_d();
        step(); step();

        // Unacked D read: synthetic err on the 5th strobe cycle, bus dropped that cycle.
        req_d(32'h0000_6000, 0, 4'hF, 32'h0);
        step();
        #1;
        chk("wd_cyc1", wbs.cyc, 1);
        chk("wd_err1", dwbm.err, 0);
        for (int k = 2; k <= 4; k++) begin
            step();
            #1 chk("wd_err_early", dwbm.err, 0);
        end
        step();
        #1;
        chk("wd_err5", dwbm.err, 1);
        chk("wd_cyc5", wbs.cyc, 0);
        chk("wd_stb5", wbs.stb, 0);
        chk("wd_ierr", iwbm.err, 0);
        step();
        #1;
        chk("wd_err6", dwbm.err, 0);
        chk("wd_cyc6", wbs.cyc, 1);
        drop_d();
        step(); step();

        // Reset during a granted fetch burst.
        req_i(32'h0000_7000, CTI_INCR, BTE_WRAP8);
        step();
        #1 chk("rb_cyc", wbs.cyc, 1);
        rst = 1; wbs.ack = 1;
        step();
        #1;
        chk("rb_rcyc", wbs.cyc, 0);
        chk("rb_rstb", wbs.stb, 0);
        chk("rb_radr", wbs.adr, 0);
        chk("rb_rcti", wbs.cti, 0);
        chk("rb_iack", iwbm.ack, 0);
        rst = 0; wbs.ack = 0;
        req_d(32'h0000_8000, 1, 4'b1100, 32'h5555_AAAA);
        step();
        #1;
        chk("rb_d_adr", wbs.adr, 32'h0000_8000);
        chk("rb_d_sel", wbs.sel, 4'b1100);
        drop_i(); drop_d();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/eco32f_wb_arbiter.md
Name: eco32f_wb_arbiter

Overview:
Two-master to one-slave Wishbone B3 arbiter between the instruction-fetch port (iwbm) and the LSU data port (dwbm) and the single external bus (wbs). Grant is held for the full cyc of a transaction, so 8-beat cache refills with wrap bursts are never interleaved. Both masters connect wbs_dat_i directly to their read-data input; this block routes only the request signals and ack/err. A watchdog converts hung transfers into err.

Parameters:
TIMEOUT, 255, cycles of granted stb without ack/err before a synthetic err is returned; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
iwbm_adr_i  in  32  fetch address
iwbm_stb_i  in  1  fetch strobe
iwbm_cyc_i  in  1  fetch cycle
iwbm_cti_i  in  3  fetch cycle type
iwbm_bte_i  in  2  fetch burst type
iwbm_ack_o  out  1  fetch ack
iwbm_err_o  out  1  fetch error
dwbm_adr_i  in  32  data address
dwbm_stb_i  in  1  data strobe
dwbm_cyc_i  in  1  data cycle
dwbm_sel_i  in  4  data byte select
dwbm_we_i  in  1  data write enable
dwbm_cti_i  in  3  data cycle type
dwbm_bte_i  in  2  data burst type
dwbm_dat_i  in  32  data write data
dwbm_ack_o  out  1  data ack
dwbm_err_o  out  1  data error
wbs_adr_o  out  32  bus address
wbs_stb_o  out  1  bus strobe
wbs_cyc_o  out  1  bus cycle
wbs_sel_o  out  4  bus byte select (4'b1111 when iwbm granted)
wbs_we_o  out  1  bus write enable (0 when iwbm granted)
wbs_cti_o  out  3  bus cycle type
wbs_bte_o  out  2  bus burst type
wbs_dat_o  out  32  bus write data (0 when iwbm granted)
wbs_ack_i  in  1  bus ack
wbs_err_i  in  1  bus error

Behaviour:
- Registered state: grant in {IDLE, GNT_I, GNT_D}, last (which master was granted last), wdog counter (8-bit for default; width clog2(TIMEOUT+1)).
- Reset: grant=IDLE, last=I, wdog=0. All wbs_* outputs and all ack/err outputs are 0 while grant=IDLE. Reset mid-transfer drops wbs_cyc_o/stb_o the following cycle.
- wbs_* outputs are a combinational mux of the granted master's inputs; in IDLE all are 0. Grant takes effect the cycle after cyc is seen (one-cycle arbitration latency).
- IDLE: only iwbm_cyc -> GNT_I; only dwbm_cyc -> GNT_D; both -> the master not equal to last (after reset D wins). On each grant, last <= granted master.
- GNT_x: held while x's cyc=1. When x drops cyc: other master cyc=1 -> switch directly to its grant (bus sees exactly one idle cycle); otherwise -> IDLE.
- Response routing: x_ack_o = wbs_ack_i & granted==x & x_stb; the same for err. The non-granted master sees ack=err=0 always.
- Watchdog (TIMEOUT>0): wdog increments each cycle granted stb=1 and wbs_ack_i=wbs_err_i=0; it clears on ack, err, stb=0 or grant change. When wdog==TIMEOUT: err pulses to the granted master for one cycle, wbs_stb_o/wbs_cyc_o are forced 0 that cycle, and wdog clears. Grant is not released until the master drops cyc.
- wbs_ack_i arriving while IDLE is ignored. Simultaneous wbs_ack_i and wbs_err_i: both are forwarded; the master handles priority.

Decomposition:
- Shared package eco32f_wb_pkg: CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111), BTE_WRAP8=2'b10, grant state encodings.
- Optional sub-module eco32f_wb_watchdog (counter plus timeout pulse), reusable on other buses. Everything else is flat.

Test Plan:
- Reset, then dwbm single write at adr 0x00000100, sel 4'b0011 -> wbs_cyc_o rises 1 cycle after dwbm_cyc_i with adr/sel/we/dat passed through; dwbm_ack_o mirrors wbs_ack_i; iwbm_ack_o stays 0.
- iwbm_cyc_i and dwbm_cyc_i assert in the same cycle after reset -> D granted first; I granted in the cycle after dwbm_cyc_i drops, with exactly one idle bus cycle between them.
- iwbm 8-beat wrap burst (cti 010, final 111, bte 10) while dwbm requests at beat 3 -> all 8 acks go to iwbm with no interleave; D granted only after iwbm_cyc_i drops.
- Back-to-back requests from both masters for 4 rounds -> grants alternate D,I,D,I,...
- TIMEOUT=4, slave never acks a dwbm read -> dwbm_err_o pulses on the 5th stb cycle; wbs_cyc_o is 0 that cycle; no err reaches iwbm.
- Assert rst during a granted iwbm burst -> next cycle all wbs_* outputs are 0; after rst deasserts, simultaneous requests grant D.
